// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared definitions for the bit-serial adder.
//   state_e   - FSM state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10)
//   cnt_width - bit-counter width for a given operand width, max(1, ceil(log2 W))
package serial_add_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned w);
    if (w <= 32'd2) begin
      return 32'd1;
    end
    return 32'($clog2(w));
  endfunction

endpackage

// File: rtl/serial_add_slice.sv
// serial_add_slice: one full-adder bit with a registered carry.
// Ports:
//   CP       in  clock, rising edge
//   CD       in  asynchronous active-low reset, clears the carry flop
//   load     in  load the carry flop from cin_load instead of the adder carry
//   cin_load in  carry value loaded when load is high
//   a, b     in  operand bits for the current position
//   s        out combinational sum bit a ^ b ^ c
//   c        out registered carry (carry-in of the current bit)
module serial_add_slice (
  input  logic CP,
  input  logic CD,
  input  logic load,
  input  logic cin_load,
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  logic r_c;
  logic w_maj;

  always_comb begin
    s     = a ^ b ^ r_c;
    w_maj = (a & b) | (a & r_c) | (b & r_c);
  end

  always_ff @(posedge CP or negedge CD) begin
    if (!CD) begin
      r_c <= 1'b0;
    end else if (load) begin
      r_c <= cin_load;
    end else begin
      r_c <= w_maj;
    end
  end

  assign c = r_c;

endmodule

// File: rtl/serial_add_n.sv
// serial_add_n: bit-serial W-bit adder, LSB first, one bit per clock.
// Ports:
//   CP    in  clock, rising edge
//   CD    in  asynchronous active-low reset
//   START in  request; accepted in IDLE or DONE, ignored while running
//   A, B  in  W-bit operands, captured on an accepted START
//   CIN   in  carry-in, captured on an accepted START
//   BUSY  out high while the sum is being resolved
//   DONE  out one-cycle pulse when S/COUT hold the new result
//   S     out W-bit sum, (A + B + CIN) mod 2^W
//   COUT  out carry out of bit W-1
module serial_add_n
  import serial_add_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         CP,
  input  logic         CD,
  input  logic         START,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         CIN,
  output logic         BUSY,
  output logic         DONE,
  output logic [W-1:0] S,
  output logic         COUT
);

  localparam int unsigned   CW      = cnt_width(W);
  localparam logic [CW-1:0] LastCnt = CW'(W - 1);

  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_sum;
  logic          r_busy;
  logic          r_done;

  logic          w_run;
  logic          w_accept;
  logic          w_slice_a;
  logic          w_slice_b;
  logic          w_s;
  logic          w_c;
  logic [W-1:0]  w_sum_next;

  always_comb begin
    w_run    = (r_state == StRun);
    w_accept = START && ((r_state == StIdle) || (r_state == StDone));
    // Outside RUN both slice inputs mirror the carry, so majority(c, c, c) = c
    // and the carry flop (which drives COUT) holds its value.
    w_slice_a = w_run ? r_a[0] : w_c;
    w_slice_b = w_run ? r_b[0] : w_c;
  end

  serial_add_slice u_slice (
    .CP       (CP),
    .CD       (CD),
    .load     (w_accept),
    .cin_load (CIN),
    .a        (w_slice_a),
    .b        (w_slice_b),
    .s        (w_s),
    .c        (w_c)
  );

  // New sum bit enters at the MSB; after W shifts bit 0 lands at position 0.
  if (W == 1) begin : g_sum_w1
    assign w_sum_next = w_s;
  end else begin : g_sum_wn
    assign w_sum_next = {w_s, r_sum[W-1:1]};
  end

  always_ff @(posedge CP or negedge CD) begin
    if (!CD) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle, StDone: begin
          if (START) begin
            r_a     <= A;
            r_b     <= B;
            r_cnt   <= '0;
            r_state <= StRun;
            r_busy  <= 1'b1;
          end else begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        end
        StRun: begin
          r_sum <= w_sum_next;
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LastCnt) begin
            r_state <= StDone;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          // Encoding 2'b11 is unreachable; recover without touching S/COUT.
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY = r_busy;
  assign DONE = r_done;
  assign S    = r_sum;
  assign COUT = w_c;

endmodule

// File: tb/tb_serial_add_n.sv
// tb_serial_add_n: scoreboard bench for serial_add_n (W=8 main instance, W=1 corner instance).
module tb_serial_add_n;

  typedef struct {
    logic [8:0] res;
    int         done_edge;
  } exp_t;

  logic       CP = 1'b0;
  logic       CD = 1'b0;
  logic       START = 1'b0;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic       CIN = 1'b0;
  logic       BUSY, DONE, COUT;
  logic [7:0] S;

  logic       START1 = 1'b0;
  logic [0:0] A1 = '0;
  logic [0:0] B1 = '0;
  logic       CIN1 = 1'b0;
  logic       BUSY1, DONE1, COUT1;
  logic [0:0] S1;

  serial_add_n #(.W(8)) dut (
    .CP(CP), .CD(CD), .START(START), .A(A), .B(B), .CIN(CIN),
    .BUSY(BUSY), .DONE(DONE), .S(S), .COUT(COUT)
  );

  serial_add_n #(.W(1)) dut1 (
    .CP(CP), .CD(CD), .START(START1), .A(A1), .B(B1), .CIN(CIN1),
    .BUSY(BUSY1), .DONE(DONE1), .S(S1), .COUT(COUT1)
  );

  always #5 CP = ~CP;

  int   cyc = 0;
  always @(posedge CP) cyc <= cyc + 1;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q[$];
  int   next_ok   = 0;
  int   acc_edge  = -1000;
  int   last_done = 0;
  logic [8:0] last_res = '0;
  logic mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: each accepted job owns edges [k, k+8]; sum is plain A+B+CIN.
  task automatic drive(input logic st, input logic [7:0] a, input logic [7:0] b,
                       input logic ci);
    int   e;
    exp_t x;
    @(negedge CP);
    START = st;
    A     = a;
    B     = b;
    CIN   = ci;
    e     = cyc + 1;
    if (st && (e >= next_ok)) begin
      x.res       = {1'b0, a} + {1'b0, b} + {8'd0, ci};
      x.done_edge = e + 8;
      q.push_back(x);
      acc_edge = e;
      next_ok  = e + 9;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    CD = 1'b0;
    q.delete();
    acc_edge  = -1000;
    next_ok   = 0;
    last_res  = '0;
    last_done = cyc;
    #1;
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_s",    32'(S),    32'd0);
    check("rst_cout", 32'(COUT), 32'd0);
    @(negedge CP);
    CD = 1'b1;
  endtask

  // Monitor / scoreboard
  initial begin
    logic eb, ed;
    forever begin
      @(negedge CP);
      if (mon_en) begin
        ed = (q.size() > 0) && (q[0].done_edge == cyc);
        eb = (cyc >= acc_edge) && (cyc < acc_edge + 8);
        check("busy", 32'(BUSY), 32'(eb));
        check("done", 32'(DONE), 32'(ed));
        if (ed) begin
          check("sum", 32'({COUT, S}), 32'(q[0].res));
          last_res  = q[0].res;
          last_done = cyc;
          void'(q.pop_front());
        end else if (last_done >= acc_edge) begin
          check("hold", 32'({COUT, S}), 32'(last_res));
        end
      end
    end
  end

  initial begin
    logic [1:0] exp1;
    repeat (2) @(negedge CP);
    do_reset();
    mon_en = 1'b1;

    // 0xFF + 0x01 wraps with carry out
    drive(1'b1, 8'hFF, 8'h01, 1'b0);
    idle(12);
    // 0x5A + 0x33 + 1, then hold for several cycles
    drive(1'b1, 8'h5A, 8'h33, 1'b1);
    idle(15);
    // START during RUN ignored
    drive(1'b1, 8'hA5, 8'h0F, 1'b0);
    idle(2);
    drive(1'b1, 8'h11, 8'h22, 1'b1);
    idle(12);
    // START held high: back-to-back jobs
    drive(1'b1, 8'h01, 8'h01, 1'b0);
    repeat (9) drive(1'b1, 8'h80, 8'h80, 1'b0);
    idle(12);
    // Reset mid-RUN aborts, then a normal job
    drive(1'b1, 8'hC3, 8'h3C, 1'b1);
    idle(3);
    @(posedge CP);
    #2;
    do_reset();
    drive(1'b1, 8'h12, 8'h34, 1'b0);
    idle(12);

    // Randomized traffic, START asserted at random, including while busy
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) == 0), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    idle(12);
    check("drain", 32'(q.size()), 32'd0);

    // W=1: every operand combination, DONE one cycle after acceptance
    for (int i = 0; i < 8; i++) begin
      @(negedge CP);
      START1 = 1'b1;
      A1     = 1'(i);
      B1     = 1'(i >> 1);
      CIN1   = 1'(i >> 2);
      exp1   = 2'(i & 1) + 2'((i >> 1) & 1) + 2'((i >> 2) & 1);
      @(negedge CP);
      START1 = 1'b0;
      check("w1_busy", 32'(BUSY1), 32'd1);
      check("w1_done_early", 32'(DONE1), 32'd0);
      @(negedge CP);
      check("w1_done", 32'(DONE1), 32'd1);
      check("w1_busy_off", 32'(BUSY1), 32'd0);
      check("w1_sum", 32'({COUT1, S1}), 32'(exp1));
      @(negedge CP);
      check("w1_done_pulse", 32'(DONE1), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_n.md
# serial_add_n

Bit-serial W-bit adder: captures two operands and a carry-in, then resolves the sum one bit per clock, LSB first, through a single full-adder slice with a registered carry. It trades latency for area and sits beside the GTECH full-adder cell as its sequential consumer: the slice's carry-out is fed back through a flop as the next bit's carry-in. Results are presented in parallel with a one-cycle DONE pulse.

## Interface
- W, default 8: operand/sum width; legal range W >= 1.
- CP  in  1  clock; all state updates on rising edge.
- CD  in  1  reset; asynchronous, active-low; clears all state.
- START  in  1  request; sampled on rising CP; accepted only in IDLE or DONE.
- A  in  W  operand A; captured on an accepted START.
- B  in  W  operand B; captured on an accepted START.
- CIN  in  1  carry-in; captured on an accepted START.
- BUSY  out  1  high while in RUN.
- DONE  out  1  one-cycle pulse; S and COUT are valid in this cycle and remain valid afterwards.
- S  out  W  sum, (A + B + CIN) mod 2^W.
- COUT  out  1  carry out of bit W-1.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: START=1 loads the A/B shift registers, sets carry flop to CIN, clears the bit counter, goes to RUN. START=0: stay.
- RUN, one bit per cycle:
  - sum_bit = a[0] ^ b[0] ^ c.
  - c <= majority(a[0], b[0], c).
  - sum register shifts right with sum_bit inserted at the MSB.
  - A/B shift registers shift right.
  - counter increments.
- When the counter reaches W-1, the next edge goes to DONE. The sum register then holds the full sum; COUT is driven from the carry flop.
- DONE, exactly one cycle:
  - START=1 is accepted as in IDLE (back-to-back operation) and goes to RUN.
  - Otherwise go to IDLE.
- START in RUN is ignored: no reload, no queuing.
- S and COUT hold their last result until the next accepted START. From that point they are undefined-but-stable, i.e. the register contents in transit. They are not guaranteed valid until DONE.
- Arithmetic:
  - Unsigned.
  - {COUT, S} = A + B + CIN, exact (W+1)-bit result.
  - No saturation.
  - Wrap-around is the normal overflow case.
- Counter width: max(1, ceil(log2 W)). With W=1, RUN lasts exactly one cycle.

## Timing
- Reset (CD low, asynchronous): state=IDLE, BUSY=0, DONE=0, S=0, COUT=0; shift registers, carry flop and counter all 0.
- CD deassertion must be synchronous to CP externally. The block does not resynchronise it.
- Reset mid-RUN aborts the operation. No DONE pulse is produced, and outputs read 0 after reset.
- Latency: START sampled at edge t0. BUSY is high from t0 to tW. DONE is high in the cycle after edge tW, i.e. W cycles after acceptance. S and COUT are valid from that same edge.
- Throughput: one result per W+1 cycles when START is held high continuously.
- DONE is never high for two consecutive cycles.
- BUSY and DONE are never high together.
- All outputs are registered. There is no combinational input-to-output path.

## Structure
- Shared package serial_add_pkg holds:
  - the state encoding constants (IDLE=2'b00, RUN=2'b01, DONE=2'b10);
  - the counter-width function.
- Sub-module serial_add_slice: one full-adder bit plus the carry flop. Its ports are CP, CD, load, cin_load, a, b, s, c.
- Top level holds the FSM, counter, operand shift registers and sum register.
- Unreachable state 2'b11 recovers to IDLE on the next edge with no output change.

## Test plan
- W=8: A=0xFF, B=0x01, CIN=0, START one cycle -> BUSY for 8 cycles; DONE pulse 8 cycles after the START edge; S=0x00, COUT=1.
- W=8: A=0x5A, B=0x33, CIN=1 -> S=0x8E, COUT=0; S/COUT unchanged 5 cycles after DONE.
- W=8: START re-pulsed with A=0x11 at cycle 3 of RUN -> ignored; result is that of the original operands; single DONE pulse.
- W=8: START held high with operands 0x01+0x01 then 0x80+0x80 -> DONE pulses 9 cycles apart; results S=0x02/COUT=0, then S=0x00/COUT=1.
- W=8: CD pulsed low at cycle 4 of RUN -> immediate BUSY=0, S=0, COUT=0; no DONE pulse; next START completes normally.
- W=1: A=1, B=1, CIN=1 -> DONE 1 cycle after START; S=1, COUT=1.
